// File: rtl/fix_sub_pipe_if.sv
// Valid/ready operand and result stream for the pipelined sign-magnitude subtractor.
// master = operand sequencer / result consumer side, slave = fix_sub_pipe.
interface fix_sub_pipe_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N:0]   minuend;
    logic [N:0]   subtrahend;
    logic         out_valid;
    logic         out_ready;
    logic [N+1:0] res;
    logic         ovf;

    modport master (
        output in_valid,
        output minuend,
        output subtrahend,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  res,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  minuend,
        input  subtrahend,
        input  out_ready,
        output in_ready,
        output out_valid,
        output res,
        output ovf
    );
endinterface

// File: rtl/fix_sub_pipe.sv
// Two-stage pipelined sign-magnitude subtractor, res = minuend - subtrahend, valid/ready on both sides.
// Optional magnitude saturation with ovf flag when FIX_SUB_SAT_EN is defined.
module fix_sub_pipe #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst,
    fix_sub_pipe_if.slave bus
);
    logic         w_adv1;
    logic         w_adv2;

    logic         r_s1Valid;
    logic         r_s1ASign;
    logic [N-1:0] r_s1AMag;
    logic         r_s1BSign;
    logic [N-1:0] r_s1BMag;
    logic         r_s1SignEq;
    logic         r_s1AGe;

    logic         r_s2Valid;
    logic [N+1:0] r_res;

    logic [N:0]   w_mag;
    logic         w_sign;

    // A stage may load whenever the stage after it is empty or moving on this cycle.
    assign w_adv2 = !r_s2Valid || bus.out_ready;
    assign w_adv1 = !r_s1Valid || w_adv2;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_s2Valid;
    assign bus.res       = r_res;

    // The subtrahend sign is flipped on entry, turning the operation into a signed add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1ASign  <= 1'b0;
            r_s1AMag   <= '0;
            r_s1BSign  <= 1'b0;
            r_s1BMag   <= '0;
            r_s1SignEq <= 1'b0;
            r_s1AGe    <= 1'b0;
        end else if (w_adv1) begin
            r_s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1ASign  <= bus.minuend[N];
                r_s1AMag   <= bus.minuend[N-1:0];
                r_s1BSign  <= ~bus.subtrahend[N];
                r_s1BMag   <= bus.subtrahend[N-1:0];
                r_s1SignEq <= (bus.minuend[N] == ~bus.subtrahend[N]);
                r_s1AGe    <= (bus.minuend[N-1:0] >= bus.subtrahend[N-1:0]);
            end
        end
    end

`ifdef FIX_SUB_SAT_EN
    localparam logic [N:0] SAT_MAG = {1'b0, {N{1'b1}}};
    logic w_ovf;
    logic r_ovf;
`endif

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
`ifdef FIX_SUB_SAT_EN
        w_ovf  = 1'b0;
`endif
        if (r_s1SignEq) begin
            w_mag  = {1'b0, r_s1AMag} + {1'b0, r_s1BMag};
            w_sign = r_s1ASign;
        end else if (r_s1AGe) begin
            w_mag  = {1'b0, r_s1AMag - r_s1BMag};
            w_sign = r_s1ASign;
        end else begin
            w_mag  = {1'b0, r_s1BMag - r_s1AMag};
            w_sign = r_s1BSign;
        end
`ifdef FIX_SUB_SAT_EN
        if (w_mag[N]) begin
            w_mag = SAT_MAG;
            w_ovf = 1'b1;
        end
`endif
        // No negative zero ever leaves the block.
        if (w_mag == '0) begin
            w_sign = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_res     <= '0;
`ifdef FIX_SUB_SAT_EN
            r_ovf     <= 1'b0;
`endif
        end else if (w_adv2) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_res <= {w_sign, w_mag};
`ifdef FIX_SUB_SAT_EN
                r_ovf <= w_ovf;
`endif
            end
        end
    end

`ifdef FIX_SUB_SAT_EN
    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_fix_sub_pipe.sv
// Self-checking bench for fix_sub_pipe: directed vectors, stall, back-to-back, reset and random traffic
// checked against a signed-integer reference model.
module tb_fix_sub_pipe;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fix_sub_pipe_if #(.N(N)) bus ();

    fix_sub_pipe #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: interpret both operands as signed integers and subtract.
    function automatic void modelSub(input logic [N:0] a, input logic [N:0] b,
                                     output logic [N+1:0] r, output logic o);
        longint va, vb, d, m, maxMag;
        logic   neg;
        va = longint'({1'b0, a[N-1:0]});
        vb = longint'({1'b0, b[N-1:0]});
        if (a[N]) va = -va;
        if (b[N]) vb = -vb;
        d      = va - vb;
        neg    = (d < 0);
        m      = neg ? -d : d;
        maxMag = (longint'(1) << N) - 1;
        o      = 1'b0;
`ifdef FIX_SUB_SAT_EN
        if (m > maxMag) begin
            m = maxMag;
            o = 1'b1;
        end
`else
        if (maxMag < 0) o = 1'b1;
`endif
        r = {neg, m[N:0]};
    endfunction

    function automatic logic [N:0] randOp();
        logic [N-1:0] m;
        case ($urandom_range(0, 5))
            0:       m = '0;
            1:       m = '1;
            2:       m = N'($urandom_range(0, 15));
            default: m = N'($urandom());
        endcase
        return {1'($urandom_range(0, 1)), m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.minuend    = '0;
        bus.subtrahend = '0;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.res !== '0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b res=%h ovf=%b, want valid=0 res=0 ovf=0",
                     bus.out_valid, bus.res, bus.ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [32:0] va [5];
        logic [32:0] vb [5];
        logic [33:0] vr [5];
        logic        vo [5];
        va[0] = 33'h0_0000_1234; vb[0] = 33'h0_0000_0123; vr[0] = 34'h0_0000_1111; vo[0] = 1'b0;
        va[1] = 33'h0_0000_0123; vb[1] = 33'h0_0000_1234; vr[1] = 34'h2_0000_1111; vo[1] = 1'b0;
`ifdef FIX_SUB_SAT_EN
        va[2] = 33'h1_FFFF_FFFF; vb[2] = 33'h0_FFFF_FFFF; vr[2] = 34'h2_FFFF_FFFF; vo[2] = 1'b1;
`else
        va[2] = 33'h1_FFFF_FFFF; vb[2] = 33'h0_FFFF_FFFF; vr[2] = 34'h3_FFFF_FFFE; vo[2] = 1'b0;
`endif
        va[3] = 33'h1_0000_0005; vb[3] = 33'h1_0000_0005; vr[3] = 34'h0;           vo[3] = 1'b0;
        va[4] = 33'h1_0000_0000; vb[4] = 33'h0_0000_0000; vr[4] = 34'h0;           vo[4] = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid   = 1'b1;
            bus.minuend    = va[i];
            bus.subtrahend = vb[i];
            step();
            bus.in_valid   = 1'b0;
            bus.minuend    = '1;
            bus.subtrahend = '1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed%0d_early: out_valid=%b one cycle after accept, want 0", i, bus.out_valid);
            end
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.res !== vr[i] || bus.ovf !== vo[i]) begin
                errors++;
                $display("[TB] FAIL directed%0d: got valid=%b res=%h ovf=%b, want valid=1 res=%h ovf=%b",
                         i, bus.out_valid, bus.res, bus.ovf, vr[i], vo[i]);
            end
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed%0d_drain: out_valid=%b, want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N:0]   a [8];
        logic [N:0]   b [8];
        logic [N+1:0] r [8];
        logic         o [8];
        for (int i = 0; i < 8; i++) begin
            a[i] = randOp();
            b[i] = randOp();
            modelSub(a[i], b[i], r[i], o[i]);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.in_valid = (k < 8);
            if (k < 8) begin
                bus.minuend    = a[k];
                bus.subtrahend = b[k];
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_in_ready%0d: got %b, want 1", k, bus.in_ready);
                end
            end
            step();
            if (k >= 1) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.res !== r[k-1] || bus.ovf !== o[k-1]) begin
                    errors++;
                    $display("[TB] FAIL b2b_out%0d: got valid=%b res=%h ovf=%b, want valid=1 res=%h ovf=%b",
                             k - 1, bus.out_valid, bus.res, bus.ovf, r[k-1], o[k-1]);
                end
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_tail: out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        logic [N:0]   a [4];
        logic [N:0]   b [4];
        logic [N+1:0] r [4];
        logic         o [4];
        int           sent = 0;
        int           recv = 0;
        logic         heldValid = 1'b0;
        logic [N+2:0] held = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = randOp();
            b[i] = randOp();
            modelSub(a[i], b[i], r[i], o[i]);
        end
        for (int c = 0; c < 20; c++) begin
            if (heldValid) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.ovf, bus.res} !== held) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%b res=%h, want valid=1 res=%h",
                             bus.out_valid, bus.res, held[N+1:0]);
                end
            end
            bus.out_ready = (c >= 3);
            bus.in_valid  = (sent < 4);
            if (sent < 4) begin
                bus.minuend    = a[sent];
                bus.subtrahend = b[sent];
            end
            #1;
            if (c == 2) begin
                checks++;
                if (bus.in_ready !== 1'b0 || sent != 2) begin
                    errors++;
                    $display("[TB] FAIL stall_in_ready: got in_ready=%b after %0d accepts, want 0 after 2",
                             bus.in_ready, sent);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (recv >= 4 || bus.res !== r[recv] || bus.ovf !== o[recv]) begin
                    errors++;
                    $display("[TB] FAIL stall_out%0d: got res=%h ovf=%b, want res=%h ovf=%b", recv,
                             bus.res, bus.ovf, r[recv % 4], o[recv % 4]);
                end
                recv++;
            end
            heldValid = bus.out_valid && !bus.out_ready;
            held      = {bus.ovf, bus.res};
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (recv != 4 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d results, out_valid=%b, want 4 results and out_valid=0",
                     recv, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid   = 1'b1;
            bus.minuend    = 33'h0_0000_0100 + 33'(i);
            bus.subtrahend = 33'h0_0000_0001;
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_full: got valid=%b in_ready=%b, want valid=1 in_ready=0",
                     bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.res !== '0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got valid=%b res=%h ovf=%b, want valid=0 res=0 ovf=0",
                     bus.out_valid, bus.res, bus.ovf);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_in_ready: got %b, want 1", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rstmid_stale%0d: out_valid=%b res=%h, want out_valid=0", i,
                         bus.out_valid, bus.res);
            end
        end
    endtask

    task automatic test_random();
        logic [N:0]   a, b;
        logic [N+1:0] r;
        logic         o;
        logic [N+2:0] q[$];
        logic [N+2:0] e;
        logic         heldValid = 1'b0;
        logic [N+2:0] held = '0;
        for (int c = 0; c < 340; c++) begin
            if (heldValid) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.ovf, bus.res} !== held) begin
                    errors++;
                    $display("[TB] FAIL rand_hold: got valid=%b res=%h, want valid=1 res=%h",
                             bus.out_valid, bus.res, held[N+1:0]);
                end
            end
            bus.out_ready  = (c >= 300) || ($urandom_range(0, 9) < 7);
            bus.in_valid   = (c < 300) && ($urandom_range(0, 9) < 7);
            a              = randOp();
            b              = randOp();
            bus.minuend    = a;
            bus.subtrahend = b;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra: unexpected res=%h, want no output", bus.res);
                end else begin
                    e = q.pop_front();
                    if ({bus.ovf, bus.res} !== e) begin
                        errors++;
                        $display("[TB] FAIL rand_res: got res=%h ovf=%b, want res=%h ovf=%b",
                                 bus.res, bus.ovf, e[N+1:0], e[N+2]);
                    end
                end
            end
            heldValid = bus.out_valid && !bus.out_ready;
            held      = {bus.ovf, bus.res};
            if (bus.in_valid && bus.in_ready) begin
                modelSub(a, b, r, o);
                q.push_back({o, r});
            end
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_drain: got %0d missing results, out_valid=%b, want 0 and 0",
                     q.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
